// File: rtl/aes_dec_input_stager_if.sv
// Word-in / block-out handshake bundle for the AES decryption input stager.
// The slave modport is the stager's view; the master modport is the driver/core view.
interface aes_dec_input_stager_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sel;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [127:0]      block_out;
    logic [127:0]      key_out;
    logic              err;

    modport slave (
        input  in_valid, in_sel, in_word, out_ready,
        output in_ready, out_valid, block_out, key_out, err
    );

    modport master (
        output in_valid, in_sel, in_word, out_ready,
        input  in_ready, out_valid, block_out, key_out, err
    );
endinterface

// File: rtl/aes_dec_input_stager.sv
// Assembles MSW-first ciphertext and key words into a 128-bit block/key pair for the AES core.
// Optional macro AES_DEC_KEY_RETAIN_EN keeps the loaded key across handoffs.
module aes_dec_input_stager #(
    parameter  int WORD_W = 32,
    localparam int NWORDS = 128 / WORD_W,
    localparam int CW     = $clog2(NWORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    aes_dec_input_stager_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t          r_state;
    logic            r_out_valid;
    logic            r_err;
    logic [127:0]    r_block;
    logic [127:0]    r_key;
    logic [CW-1:0]   r_dcnt;
    logic [CW-1:0]   r_kcnt;
    logic            r_dcomp;
    logic            r_kcomp;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_extra;
    logic            w_dlast;
    logic            w_klast;
    logic            w_dset;
    logic            w_kset;
    logic            w_both;
    logic [6:0]      w_dbase;
    logic [6:0]      w_kbase;

    assign w_in_ready = (r_state != FULL);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_extra    = w_accept && (bus.in_sel ? r_kcomp : r_dcomp);
    assign w_dlast    = (r_dcnt == CW'(NWORDS - 1));
    assign w_klast    = (r_kcnt == CW'(NWORDS - 1));
    assign w_dset     = w_accept && !bus.in_sel && !r_dcomp && w_dlast;
    assign w_kset     = w_accept &&  bus.in_sel && !r_kcomp && w_klast;
    assign w_both     = (r_dcomp || w_dset) && (r_kcomp || w_kset);

    // Slice base for the word at counter position cnt, most-significant word first.
    assign w_dbase    = 7'd127 - 7'(WORD_W * r_dcnt);
    assign w_kbase    = 7'd127 - 7'(WORD_W * r_kcnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_block     <= '0;
            r_key       <= '0;
            r_dcnt      <= '0;
            r_kcnt      <= '0;
            r_dcomp     <= 1'b0;
            r_kcomp     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (flush) begin
                // Data registers are deliberately left intact; only bookkeeping is cleared.
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_dcnt      <= '0;
                r_kcnt      <= '0;
                r_dcomp     <= 1'b0;
                r_kcomp     <= 1'b0;
            end else if (r_state == FULL) begin
                if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_dcnt      <= '0;
                    r_dcomp     <= 1'b0;
`ifdef AES_DEC_KEY_RETAIN_EN
                    r_state     <= COLLECT;
`else
                    r_kcnt      <= '0;
                    r_kcomp     <= 1'b0;
                    r_state     <= IDLE;
`endif
                end
            end else if (w_accept) begin
                if (w_extra) begin
                    r_err <= 1'b1;
                end else if (bus.in_sel) begin
                    r_key[w_kbase -: WORD_W] <= bus.in_word;
                    r_kcnt <= r_kcnt + CW'(1);
                    if (w_klast) r_kcomp <= 1'b1;
                end else begin
                    r_block[w_dbase -: WORD_W] <= bus.in_word;
                    r_dcnt <= r_dcnt + CW'(1);
                    if (w_dlast) r_dcomp <= 1'b1;
                end
                if (w_both) begin
                    r_state     <= FULL;
                    r_out_valid <= 1'b1;
                end else begin
                    r_state     <= COLLECT;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.err       = r_err;
    assign bus.block_out = r_block;
    assign bus.key_out   = r_key;
endmodule

// File: tb/tb_aes_dec_input_stager.sv
// Bench for aes_dec_input_stager: vector table, directed corner sequences, then random traffic
// against a queue-based reference model.
module tb_aes_dec_input_stager;
    localparam int W  = 32;
    localparam int NW = 128 / W;

    logic clk;
    logic rst_n;
    logic flush;
    int   total;
    int   bad;

    aes_dec_input_stager_if #(.WORD_W(W)) bus();

    aes_dec_input_stager #(.WORD_W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sel;
        logic [W-1:0] word;
        logic         exp_err;
        logic         exp_ov;
    } vec_t;

    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] BLK0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BLK1 = 128'h3925841d02dc09fbdc118597196a0b32;

    vec_t tv[9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] wd(input logic [127:0] v, input int i);
        return v[127 - W*i -: W];
    endfunction

    task automatic send(input logic sel, input logic [W-1:0] word);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_word  = word;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Reference model: words collected per target, and the FULL condition.
    logic [W-1:0] mdq[$];
    logic [W-1:0] mkq[$];
    bit           mfull;
    bit           merr;
    logic [127:0] mblk;
    logic [127:0] mkey;

    task automatic model_step();
        merr = 1'b0;
        if (flush) begin
            mdq.delete();
            mkq.delete();
            mfull = 1'b0;
        end else if (mfull) begin
            if (bus.out_ready) begin
                mfull = 1'b0;
                mdq.delete();
`ifndef AES_DEC_KEY_RETAIN_EN
                mkq.delete();
`endif
            end
        end else if (bus.in_valid) begin
            if (bus.in_sel) begin
                if (mkq.size() == NW) merr = 1'b1;
                else mkq.push_back(bus.in_word);
            end else begin
                if (mdq.size() == NW) merr = 1'b1;
                else mdq.push_back(bus.in_word);
            end
            if (mdq.size() == NW && mkq.size() == NW) begin
                mfull = 1'b1;
                mblk  = '0;
                mkey  = '0;
                for (int i = 0; i < NW; i++) begin
                    mblk = {mblk[127-W:0], mdq[i]};
                    mkey = {mkey[127-W:0], mkq[i]};
                end
            end
        end
    endtask

    initial begin
        logic [127:0] hold_b;
        logic [127:0] hold_k;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b0;

        // Interleaved load with a fifth key word slipped in before the last data word.
        for (int i = 0; i < 3; i++) begin
            tv[2*i]   = '{1'b1, wd(KEY0, i), 1'b0, 1'b0};
            tv[2*i+1] = '{1'b0, wd(BLK0, i), 1'b0, 1'b0};
        end
        tv[6] = '{1'b1, wd(KEY0, 3), 1'b0, 1'b0};
        tv[7] = '{1'b1, 32'hdeadbeef, 1'b1, 1'b0};
        tv[8] = '{1'b0, wd(BLK0, 3), 1'b0, 1'b1};

        #1;
        chk("rst_ov", bus.out_valid, 0);
        chk("rst_rdy", bus.in_ready, 1);
        chk("rst_err", bus.err, 0);
        chk("rst_blk", bus.block_out, 0);
        chk("rst_key", bus.key_out, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = tv[i].sel;
            bus.in_word  = tv[i].word;
            tick();
            chk($sformatf("tv%0d_err", i), bus.err, tv[i].exp_err);
            chk($sformatf("tv%0d_ov", i), bus.out_valid, tv[i].exp_ov);
        end
        chk("ld_blk", bus.block_out, BLK0);
        chk("ld_key", bus.key_out, KEY0);
        chk("ld_rdy", bus.in_ready, 0);

        // Backpressure: words offered while FULL must be ignored.
        hold_b = bus.block_out;
        hold_k = bus.key_out;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 1'($urandom_range(0, 1));
            bus.in_word  = $urandom;
            tick();
            chk("bp_ov", bus.out_valid, 1);
            chk("bp_rdy", bus.in_ready, 0);
            chk("bp_err", bus.err, 0);
            chk("bp_blk", bus.block_out, hold_b);
            chk("bp_key", bus.key_out, hold_k);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("ho_ov", bus.out_valid, 0);
        chk("ho_rdy", bus.in_ready, 1);

        // Only ciphertext after the handoff.
        for (int i = 0; i < NW; i++) send(1'b0, wd(BLK1, i));
        tick();
`ifdef AES_DEC_KEY_RETAIN_EN
        chk("ret_ov", bus.out_valid, 1);
        chk("ret_key", bus.key_out, KEY0);
        chk("ret_blk", bus.block_out, BLK1);
        send(1'b1, 32'h12345678);
        chk("ret_xerr", bus.err, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        send(1'b1, 32'h12345678);
        chk("ret_err", bus.err, 1);
        chk("ret_key2", bus.key_out, KEY0);
`else
        chk("nret_ov", bus.out_valid, 0);
        chk("nret_rdy", bus.in_ready, 1);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Partial load, flush, then a full reload must not reuse stale counts.
        send(1'b0, 32'h11111111);
        send(1'b0, 32'h22222222);
        for (int i = 0; i < 3; i++) send(1'b1, 32'h33333333);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_ov", bus.out_valid, 0);
        chk("fl_rdy", bus.in_ready, 1);
        for (int i = 0; i < NW; i++) begin
            send(1'b0, wd(BLK1, i));
            chk("fl_ov_d", bus.out_valid, 0);
        end
        for (int i = 0; i < NW; i++) begin
            send(1'b1, wd(KEY1, i));
            chk("fl_ov_k", bus.out_valid, (i == NW - 1) ? 1'b1 : 1'b0);
        end
        chk("fl_blk", bus.block_out, BLK1);
        chk("fl_key", bus.key_out, KEY1);

        // Asynchronous reset from FULL, mid-cycle.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_ov", bus.out_valid, 0);
        chk("ar_rdy", bus.in_ready, 1);
        chk("ar_blk", bus.block_out, 0);
        chk("ar_key", bus.key_out, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic against the reference model.
        mdq.delete();
        mkq.delete();
        mfull = 1'b0;
        merr  = 1'b0;
        mblk  = '0;
        mkey  = '0;
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_sel    = 1'($urandom_range(0, 1));
            bus.in_word   = $urandom;
            bus.out_ready = ($urandom_range(0, 2) == 0);
            flush         = ($urandom_range(0, 40) == 0);
            @(posedge clk);
            model_step();
            #1;
            chk("rnd_rdy", bus.in_ready, !mfull);
            chk("rnd_ov", bus.out_valid, mfull);
            chk("rnd_err", bus.err, merr);
            if (mfull) begin
                chk("rnd_blk", bus.block_out, mblk);
                chk("rnd_key", bus.key_out, mkey);
            end
        end
        bus.in_valid = 1'b0;
        flush        = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
